mem_access_unit: RTL and testbench

Load/store front end sitting directly upstream of the 64-bit word RAM, between the core's memory stage and the RAM port. It accepts byte, half, word and double accesses over a valid/ready request channel. It checks natural alignment and performs read-modify-write for sub-doubleword stores, since the RAM only writes whole 8-byte cells. Each access returns one response on a valid/ready response channel, carrying sign- or zero-extended load data and a fault code.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_lane.sv | 38 +++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_pkg : size, fault and state encodings for mem_access_unit | rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_ACCESS   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00FF;
      SZ_H:    return 64'h0000_0000_0000_FFFF;
      SZ_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane.sv
// +--------------------------------------------------------------------------+
// | mem_lane : cell lane extraction/extension and store merge | rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_lane
  import mem_pkg::*;
(
  input  logic [63:0] cell_i,
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_o,
  output logic [63:0] merged_o
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] mask;

  assign shamt = {offset_i, 3'b000};

  always_comb begin
    mask = size_mask(size_i);
    lane = cell_i >> shamt;
    case (size_i)
      SZ_B:    load_o = unsigned_i ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      SZ_H:    load_o = unsigned_i ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      SZ_W:    load_o = unsigned_i ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_o = lane;
    endcase
    merged_o = (cell_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit : aligned load/store front end with RMW to 64b RAM | r1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RAM_WIDTH = 12,
  parameter int BUS_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [1:0]  rsp_fault,
  output logic        ram_rw,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_write,
  input  logic [63:0] ram_read,
  input  logic        ram_exception
);

  state_e      state_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] merged_q;
  logic [63:0] rdata_q;
  logic [1:0]  fault_q;

  logic [63:0] lane_load;
  logic [63:0] lane_merged;
  logic        out_of_range;
  logic        access_err;

  mem_lane u_lane (
    .cell_i     (ram_read),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  // Mirrors the RAM's own range check so a mis-wired exception still faults.
  assign out_of_range = |addr_q[63:RAM_WIDTH];
  assign access_err   = ram_exception | out_of_range;

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  // Gated by rst_n so a reset landing in the write cycle cannot commit a cell.
  assign ram_rw    = rst_n && (state_q == ST_WRITE);
  assign ram_write = ram_rw ? merged_q : 64'd0;
  assign ram_addr  = {addr_q[63:BUS_WIDTH], {BUS_WIDTH{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SZ_B;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      merged_q <= 64'd0;
      rdata_q  <= 64'd0;
      fault_q  <= FLT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 64'd0;
            fault_q <= FLT_NONE;
            if ((req_addr[2:0] & align_mask(req_size)) != 3'b000) begin
              fault_q <= FLT_MISALIGN;
              state_q <= ST_RESP;
            end else if (req_we && (req_size == SZ_D)) begin
              merged_q <= req_wdata;
              state_q  <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (access_err) begin
            fault_q <= FLT_ACCESS;
            state_q <= ST_RESP;
          end else if (we_q) begin
            merged_q <= lane_merged;
            state_q  <= ST_WRITE;
          end else begin
            rdata_q <= lane_load;
            state_q <= ST_RESP;
          end
        end
        ST_WRITE: begin
          if (access_err) begin
            fault_q <= FLT_ACCESS;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_unit : scoreboard bench for mem_access_unit | rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int RAM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic        ram_rw;
  logic [63:0] ram_addr;
  logic [63:0] ram_write;
  logic [63:0] ram_read;
  logic        ram_exception;

  mem_access_unit #(.RAM_WIDTH(12), .BUS_WIDTH(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_fault     (rsp_fault),
    .ram_rw        (ram_rw),
    .ram_addr      (ram_addr),
    .ram_write     (ram_write),
    .ram_read      (ram_read),
    .ram_exception (ram_exception)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Word RAM seen by the DUT, and an independent byte-addressed reference image.
  logic [63:0] ram_cells [512];
  logic [7:0]  ref_mem [RAM_BYTES];

  assign ram_exception = (ram_addr >= 64'(RAM_BYTES));
  assign ram_read      = ram_exception ? 64'd0 : ram_cells[ram_addr[11:3]];
  always @(posedge clk) if (ram_rw && !ram_exception) ram_cells[ram_addr[11:3]] <= ram_write;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  fault;
    int          first_cyc;
    bit          has_rw;
    int          rw_cyc;
    logic [63:0] rw_addr;
    logic [63:0] rw_data;
  } exp_t;

  typedef struct {
    int          c;
    logic [63:0] a;
    logic [63:0] d;
  } rw_t;

  exp_t exp_q[$];
  rw_t  rw_log[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference behaviour from the access rules, on the byte image.
  task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                       input logic [63:0] wd, input int acc, output exp_t e);
    int          n;
    logic [63:0] v;
    logic [11:0] ia;
    n = 1 << sz;
    e = '{rdata: 64'd0, fault: 2'd0, first_cyc: 0, has_rw: 1'b0, rw_cyc: 0, rw_addr: 64'd0, rw_data: 64'd0};
    if ((addr % 64'(n)) != 64'd0) begin
      e.fault = 2'd1;
      e.first_cyc = acc + 1;
      return;
    end
    if (addr >= 64'(RAM_BYTES)) begin
      e.fault = 2'd2;
      e.first_cyc = acc + 2;
      if (we && n == 8) begin
        e.has_rw = 1'b1; e.rw_cyc = acc + 1; e.rw_addr = addr & ~64'd7; e.rw_data = wd;
      end
      return;
    end
    if (!we) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) begin
        ia = addr[11:0] + 12'(i);
        v = v | (64'(ref_mem[ia]) << (8 * i));
      end
      if (!uns && n < 8 && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
      e.rdata = v;
      e.first_cyc = acc + 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        ia = addr[11:0] + 12'(i);
        ref_mem[ia] = wd[8*i +: 8];
      end
      v = 64'd0;
      for (int i = 0; i < 8; i++) begin
        ia = {addr[11:3], 3'b000} + 12'(i);
        v = v | (64'(ref_mem[ia]) << (8 * i));
      end
      e.has_rw = 1'b1;
      e.rw_addr = addr & ~64'd7;
      e.rw_data = v;
      e.rw_cyc = acc + ((n == 8) ? 1 : 2);
      e.first_cyc = acc + ((n == 8) ? 2 : 3);
    end
  endtask

  // Monitor: logs RAM writes and checks each response at its handshake.
  bit   mon_prev_v = 1'b0;
  int   mon_first = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (ram_rw) rw_log.push_back('{cyc, ram_addr, ram_write});
      else chk("ram_write_idle", ram_write, 64'd0);
      if (rsp_valid && !mon_prev_v) mon_first = cyc;
      mon_prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_fault", 64'(rsp_fault), 64'(mon_e.fault));
          chk("rsp_latency", 64'(mon_first), 64'(mon_e.first_cyc));
          chk("rw_pulses", 64'(rw_log.size()), 64'(mon_e.has_rw));
          if (mon_e.has_rw && rw_log.size() > 0) begin
            chk("rw_cycle", 64'(rw_log[0].c), 64'(mon_e.rw_cyc));
            chk("rw_addr", rw_log[0].a, mon_e.rw_addr);
            chk("rw_data", rw_log[0].d, mon_e.rw_data);
          end
          rw_log.delete();
        end
      end
    end
  end

  task automatic finish_now();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Called at a negedge; returns the accept cycle.
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                       input logic [63:0] wd, output int acc);
    int w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'd1);
      finish_now();
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    acc = cyc;
  endtask

  task automatic access(input bit we, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                        input logic [63:0] wd, input int hold);
    exp_t e;
    int   acc;
    int   w;
    issue(we, sz, uns, addr, wd, acc);
    model(we, sz, uns, addr, wd, acc, e);
    exp_q.push_back(e);
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    w = 0;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
      exp_q.delete();
      rsp_ready = 1'b1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      if (exp_q.size() > 0) begin
        chk("hold_rdata", rsp_rdata, exp_q[0].rdata);
        chk("hold_fault", 64'(rsp_fault), 64'(exp_q[0].fault));
      end
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  task automatic set_cell(input int idx, input logic [63:0] v);
    ram_cells[idx] = v;
    for (int b = 0; b < 8; b++) ref_mem[idx*8+b] = v[8*b +: 8];
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_fault"}, 64'(rsp_fault), 64'd0);
    chk({tag, "_ram_rw"}, 64'(ram_rw), 64'd0);
    chk({tag, "_ram_addr"}, ram_addr, 64'd0);
    chk({tag, "_ram_write"}, ram_write, 64'd0);
  endtask

  // Abandon an access by pulsing reset at the given cycle after accept.
  task automatic reset_mid(input bit we, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] wd, input bit in_write);
    int acc;
    issue(we, sz, 1'b0, addr, wd, acc);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (in_write) chk("write_cycle_rw", 64'(ram_rw), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_forces_rw_low", 64'(ram_rw), 64'd0);
    @(negedge clk);
    chk_reset_outs("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    chk("no_rw_after_rst", 64'(rw_log.size()), 64'd0);
    rw_log.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [1:0]  r_sz;
  logic [63:0] r_addr;
  bit          r_we, r_uns;

  initial begin
    for (int i = 0; i < 512; i++) set_cell(i, {$urandom, $urandom});
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_out_of_reset", 64'(req_ready), 64'd1);

    set_cell(2, 64'h8877_6655_4433_2211);
    access(1'b0, SZ_B, 1'b0, 64'h17, 64'd0, 0);
    access(1'b0, SZ_B, 1'b1, 64'h17, 64'd0, 0);
    access(1'b1, SZ_H, 1'b0, 64'h12, 64'hBEEF, 0);
    access(1'b0, SZ_D, 1'b0, 64'h10, 64'd0, 0);
    access(1'b0, SZ_W, 1'b0, 64'h6, 64'd0, 0);
    access(1'b0, SZ_H, 1'b0, 64'h2000, 64'd0, 0);
    access(1'b1, SZ_B, 1'b0, 64'h2000, 64'h5A, 0);
    access(1'b1, SZ_D, 1'b0, 64'h2000, 64'h1122_3344_5566_7788, 0);
    access(1'b0, SZ_D, 1'b0, 64'h10, 64'd0, 3);
    access(1'b0, SZ_H, 1'b0, 64'h14, 64'd0, 0);

    reset_mid(1'b1, SZ_B, 64'h30, 64'hAB, 1'b0);
    access(1'b0, SZ_D, 1'b0, 64'h30, 64'd0, 0);
    reset_mid(1'b1, SZ_D, 64'h38, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    access(1'b0, SZ_D, 1'b0, 64'h38, 64'd0, 0);

    for (int k = 0; k < 300; k++) begin
      r_sz  = 2'($urandom_range(0, 3));
      r_we  = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 5) r_addr = 64'h2000 + 64'($urandom_range(0, 255));
      else r_addr = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((64'd1 << r_sz) - 64'd1);
      access(r_we, r_sz, r_uns, r_addr, {$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    finish_now();
  end

endmodule

`default_nettype wire
